dac_waveform_engine: RTL
========================

// Module: dac_waveform_engine
// PURPOSE
// Parametrised voltammetry waveform sequencer driving one DAC controller's data/set inputs.
// Generalises the fixed 8-bit square-wave engine to N-bit codes with three modes: staircase, SWV and cyclic.
// It sits between the host wire/trigger endpoints and a dacOKInterface-style controller.
// While running, it asserts shield so the top level muxes its code over the pipe data.
// PARAMETERS
// DATA_WIDTH  8   DAC code width; also width of start/stop/amp
// STEP_WIDTH  8   staircase increment width
// CNT_WIDTH   24  half-period counter width, in ti_clk cycles
// CYC_WIDTH   8   cyclic-mode repeat count width
// PORTS
// ti_clk      in   1           system clock; all logic rising-edge
// rst_n       in   1           asynchronous active-low reset
// cfg_start   in   DATA_WIDTH  initial base code
// cfg_stop    in   DATA_WIDTH  final/vertex base code
// cfg_step    in   STEP_WIDTH  base increment per step (0 = hold at start)
// cfg_amp     in   DATA_WIDTH  SWV pulse amplitude
// cfg_half    in   CNT_WIDTH   half-period length in cycles (0 treated as 1)
// cfg_mode    in   2           0 staircase, 1 SWV, 2 cyclic, 3 reserved
// cfg_cycles  in   CYC_WIDTH   cyclic repeats (0 treated as 1)
// start_trig  in   1           1-cycle pulse: latch cfg_*, begin run
// abort_trig  in   1           1-cycle pulse: stop immediately
// dac_busy    in   1           DAC controller cannot accept a new code
// dac_data    out  DATA_WIDTH  current code
// dac_set     out  1           1-cycle strobe: dac_data is a new code
// shield      out  1           high while a run is in progress
// busy        out  1           high outside IDLE
// done        out  1           1-cycle pulse on normal completion
// overrun     out  1           sticky: an update was dropped while dac_busy
// BEHAVIOUR
// - Reset: state IDLE; dac_data=0; dac_set, shield, busy, done, overrun=0; shadow cfg=0.
// - FSM: IDLE -> RUN_HI on start_trig if cfg_mode!=3 (mode 3: ignored, stays IDLE).
//   RUN_HI -> RUN_LO -> (next step) RUN_HI; RUN_LO -> IDLE after final step.
//   Each state lasts cfg_half cycles.
// - start_trig while busy is ignored. abort_trig in any state -> IDLE next cycle.
//   On abort: shield/busy low, no done pulse, dac_data holds its value. abort beats start in the same cycle.
// - Config is shadowed at the accepted start_trig; cfg_* changes mid-run have no effect.
//   overrun clears at accepted start.
// - Latency: start_trig at cycle N -> dac_set=1 with the first code at N+1; shield/busy high from N+1.
// - Direction: up if stop>=start, else down. The base moves by cfg_step after each RUN_LO.
//   If the next base would pass stop, it is clamped to stop and that step is final.
//   Arithmetic is done in DATA_WIDTH+2 bits.
// - Mode 0 code = base in both halves; dac_set only at step boundaries.
// - Mode 1 code = sat(base+amp) in RUN_HI and sat(base-amp) in RUN_LO, saturated to [0, 2^DATA_WIDTH-1].
//   dac_set at every half boundary.
// - Mode 2 = staircase start->stop, then stop->start (reversed direction, vertex step not repeated).
//   This repeats cfg_cycles times, ending at start.
// - dac_set gating: if a code is due while dac_busy=1, the strobe is deferred until the first cycle dac_busy=0.
//   dac_data updates immediately; the timer keeps running.
//   A second code due while still deferred replaces the pending code and sets overrun.
// - Completion: when the final RUN_LO expires -> done=1 for 1 cycle, shield/busy=0 the same cycle, dac_data held.
//   A pending deferred strobe is discarded at completion/abort.
// - start_trig in the same cycle as done: accepted (IDLE entered that edge).
// TESTING
// 1. Mode 0: start=10, stop=13, step=1, half=4, busy=0 -> dac_set codes 10,11,12,13 every 8 cycles; done 32 cycles after first set.
// 2. Mode 1: start=100, stop=102, step=2, amp=5, half=3 -> codes 105,95,107,97 with a set every 3 cycles; then done.
// 3. Saturation: DATA_WIDTH=8, mode 1, start=250, stop=250, amp=10 -> codes 255 then 240; start=3, amp=10 -> 13 then 0.
// 4. Mode 2: start=5, stop=7, step=1, cycles=2 -> bases 5,6,7,6,5,6,7,6,5; done; shield low.
// 5. Hold dac_busy=1 across two half boundaries -> one dac_set after busy falls, carrying the latest code; overrun=1 until next start.
// 6. abort_trig mid-run -> busy/shield 0 next cycle, no done; assert rst_n=0 mid-run -> all outputs at reset values immediately.

Source files
------------

// File: rtl/dac_waveform_engine.sv
// Voltammetry waveform sequencer: staircase, square-wave (SWV) and cyclic sweeps
// feeding a DAC controller's data/set inputs, with busy-aware strobe deferral.
module dac_waveform_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int STEP_WIDTH = 8,
  parameter int CNT_WIDTH  = 24,
  parameter int CYC_WIDTH  = 8
) (
  input  logic                  ti_clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] cfg_start,
  input  logic [DATA_WIDTH-1:0] cfg_stop,
  input  logic [STEP_WIDTH-1:0] cfg_step,
  input  logic [DATA_WIDTH-1:0] cfg_amp,
  input  logic [CNT_WIDTH-1:0]  cfg_half,
  input  logic [1:0]            cfg_mode,
  input  logic [CYC_WIDTH-1:0]  cfg_cycles,
  input  logic                  start_trig,
  input  logic                  abort_trig,
  input  logic                  dac_busy,
  output logic [DATA_WIDTH-1:0] dac_data,
  output logic                  dac_set,
  output logic                  shield,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);
  localparam int XW = DATA_WIDTH + 2;
  localparam logic signed [XW-1:0] MAX_X = {2'b00, {DATA_WIDTH{1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN_HI, RUN_LO} state_e;

  function automatic logic [DATA_WIDTH-1:0] pulse_code(input logic [DATA_WIDTH-1:0] base,
                                                       input logic [DATA_WIDTH-1:0] amp,
                                                       input logic hi);
    logic signed [XW-1:0] s;
    s = hi ? ($signed({2'b00, base}) + $signed({2'b00, amp}))
           : ($signed({2'b00, base}) - $signed({2'b00, amp}));
    if (s < 0) return '0;
    else if (s > MAX_X) return '1;
    else return s[DATA_WIDTH-1:0];
  endfunction

  // Next base one step towards target; landing on or beyond target clamps to it.
  function automatic logic [DATA_WIDTH-1:0] step_next(input logic [DATA_WIDTH-1:0] base,
                                                      input logic [STEP_WIDTH-1:0] step,
                                                      input logic [DATA_WIDTH-1:0] target,
                                                      input logic up);
    logic signed [XW-1:0] s;
    logic signed [XW-1:0] t;
    t = $signed({2'b00, target});
    s = up ? ($signed({2'b00, base}) + $signed(XW'(step)))
           : ($signed({2'b00, base}) - $signed(XW'(step)));
    if (up ? (s >= t) : (s <= t)) return target;
    else return s[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] half_m1(input logic [CNT_WIDTH-1:0] h);
    return (h == '0) ? '0 : h - 1'b1;
  endfunction

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    timer_q, timer_d, half_q, half_d;
  logic [DATA_WIDTH-1:0]   base_q, base_d, target_q, target_d, data_q, data_d;
  logic [DATA_WIDTH-1:0]   start_q, start_d, stop_q, stop_d, amp_q, amp_d;
  logic [STEP_WIDTH-1:0]   step_q, step_d;
  logic [CYC_WIDTH-1:0]    cyc_q, cyc_d;
  logic [1:0]              mode_q, mode_d;
  logic                    up_q, up_d, leg_q, leg_d;
  logic                    pend_q, pend_d, overrun_q, overrun_d, done_q, done_d;
  logic                    code_due, leg_end;
  logic [DATA_WIDTH-1:0]   new_code, nb;

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      half_q    <= '0;
      base_q    <= '0;
      target_q  <= '0;
      data_q    <= '0;
      start_q   <= '0;
      stop_q    <= '0;
      amp_q     <= '0;
      step_q    <= '0;
      cyc_q     <= '0;
      mode_q    <= '0;
      up_q      <= 1'b0;
      leg_q     <= 1'b0;
      pend_q    <= 1'b0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      half_q    <= half_d;
      base_q    <= base_d;
      target_q  <= target_d;
      data_q    <= data_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      amp_q     <= amp_d;
      step_q    <= step_d;
      cyc_q     <= cyc_d;
      mode_q    <= mode_d;
      up_q      <= up_d;
      leg_q     <= leg_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = (timer_q == '0) ? '0 : timer_q - 1'b1;
    half_d    = half_q;
    base_d    = base_q;
    target_d  = target_q;
    data_d    = data_q;
    start_d   = start_q;
    stop_d    = stop_q;
    amp_d     = amp_q;
    step_d    = step_q;
    cyc_d     = cyc_q;
    mode_d    = mode_q;
    up_d      = up_q;
    leg_d     = leg_q;
    overrun_d = overrun_q;
    done_d    = 1'b0;
    pend_d    = pend_q & dac_busy;
    code_due  = 1'b0;
    new_code  = data_q;
    nb        = base_q;
    leg_end   = (base_q == target_q) || (step_q == '0);

    if (abort_trig) begin
      state_d = IDLE;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_trig && cfg_mode != 2'd3) begin
            state_d   = RUN_HI;
            start_d   = cfg_start;
            stop_d    = cfg_stop;
            amp_d     = cfg_amp;
            step_d    = cfg_step;
            half_d    = cfg_half;
            mode_d    = cfg_mode;
            cyc_d     = (cfg_cycles == '0) ? CYC_WIDTH'(1) : cfg_cycles;
            up_d      = (cfg_stop >= cfg_start);
            leg_d     = 1'b0;
            base_d    = cfg_start;
            target_d  = cfg_stop;
            timer_d   = half_m1(cfg_half);
            overrun_d = 1'b0;
            code_due  = 1'b1;
            new_code  = (cfg_mode == 2'd1) ? pulse_code(cfg_start, cfg_amp, 1'b1) : cfg_start;
          end
        end
        RUN_HI: begin
          if (timer_q == '0) begin
            state_d = RUN_LO;
            timer_d = half_m1(half_q);
            if (mode_q == 2'd1) begin
              code_due = 1'b1;
              new_code = pulse_code(base_q, amp_q, 1'b0);
            end
          end
        end
        RUN_LO: begin
          if (timer_q == '0) begin
            // In cyclic mode a leg end flips direction; the vertex is not re-emitted.
            if (!leg_end) begin
              nb = step_next(base_q, step_q, target_q, up_q);
            end else if (mode_q == 2'd2 && !leg_q) begin
              leg_d    = 1'b1;
              up_d     = ~up_q;
              target_d = start_q;
              nb       = step_next(base_q, step_q, start_q, ~up_q);
            end else if (mode_q == 2'd2 && cyc_q > CYC_WIDTH'(1)) begin
              leg_d    = 1'b0;
              cyc_d    = cyc_q - 1'b1;
              up_d     = ~up_q;
              target_d = stop_q;
              nb       = step_next(base_q, step_q, stop_q, ~up_q);
            end
            if (leg_end && !(mode_q == 2'd2 && (!leg_q || cyc_q > CYC_WIDTH'(1)))) begin
              state_d = IDLE;
              done_d  = 1'b1;
              pend_d  = 1'b0;
            end else begin
              state_d  = RUN_HI;
              timer_d  = half_m1(half_q);
              base_d   = nb;
              code_due = 1'b1;
              new_code = (mode_q == 2'd1) ? pulse_code(nb, amp_q, 1'b1) : nb;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A code arriving while an earlier one is still blocked replaces it.
    if (code_due) begin
      data_d = new_code;
      pend_d = 1'b1;
      if (pend_q && dac_busy) overrun_d = 1'b1;
    end
  end

  assign dac_data = data_q;
  assign dac_set  = pend_q & ~dac_busy;
  assign busy     = (state_q != IDLE);
  assign shield   = (state_q != IDLE);
  assign done     = done_q;
  assign overrun  = overrun_q;
endmodule
